// File: rtl/tail_light_pkg.sv
// Shared types and default constants for the tail-light input conditioning slice.
package tail_light_pkg;

  typedef enum logic {DB_STABLE, DB_CHECK} db_state_e;

  localparam int SYNC_STAGES_D = 2;
  localparam int DB_CYCLES_D   = 8;
  localparam int TICK_DIV_D    = 4;

endpackage

// File: rtl/turn_signal_input_if.sv
// Switch inputs, debounced levels, tick and sequencer requests of the turn-signal front end.
interface turn_signal_input_if;
  logic left_sw;
  logic right_sw;
  logic haz_sw;
  logic left_db;
  logic right_db;
  logic haz_db;
  logic tick;
  logic a;
  logic b;

  modport master (
    output left_sw, right_sw, haz_sw,
    input  left_db, right_db, haz_db, tick, a, b
  );

  modport slave (
    input  left_sw, right_sw, haz_sw,
    output left_db, right_db, haz_db, tick, a, b
  );
endinterface

// File: rtl/sw_debounce.sv
// One switch channel: SYNC_STAGES-deep synchronizer followed by a two-state debounce FSM.
module sw_debounce
  import tail_light_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DB_CYCLES   = DB_CYCLES_D
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  db_state_e              state_q;
  logic [CW-1:0]          cnt_q;
  logic                   db_q;
  logic                   s;

  assign s    = sync_q[SYNC_STAGES-1];
  assign db_o = db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // A single-cycle debounce has no CHECK dwell, so it flips straight from STABLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      case (state_q)
        DB_STABLE: begin
          cnt_q <= '0;
          if (s != db_q) begin
            if (DB_CYCLES == 1) begin
              db_q <= ~db_q;
            end else begin
              state_q <= DB_CHECK;
              cnt_q   <= CW'(1);
            end
          end
        end
        DB_CHECK: begin
          if (s == db_q) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            db_q    <= ~db_q;
            cnt_q   <= '0;
            state_q <= DB_STABLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= DB_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/turn_signal_input.sv
// Debounces left/right/hazard switches and presents tick-aligned a/b requests to the sequencer.
module turn_signal_input
  import tail_light_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DB_CYCLES   = DB_CYCLES_D,
  parameter int TICK_DIV    = TICK_DIV_D
) (
  input logic               clk,
  input logic               reset,
  turn_signal_input_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic          left_db, right_db, haz_db;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic          req_a, req_b;
  logic          a_q, b_q;

  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_left (
    .clk(clk), .reset(reset), .raw_i(bus.left_sw), .db_o(left_db)
  );
  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_right (
    .clk(clk), .reset(reset), .raw_i(bus.right_sw), .db_o(right_db)
  );
  sw_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_haz (
    .clk(clk), .reset(reset), .raw_i(bus.haz_sw), .db_o(haz_db)
  );

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  // tick decodes straight off the counter register, so reset clears it immediately.
  assign tick  = (tick_cnt_q == TICK_LAST);
  assign req_a = left_db  | haz_db;
  assign req_b = right_db | haz_db;

  // a and b load together so a two-sided request is never seen half-applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else if (tick) begin
      a_q <= req_a;
      b_q <= req_b;
    end
  end

  assign bus.left_db  = left_db;
  assign bus.right_db = right_db;
  assign bus.haz_db   = haz_db;
  assign bus.tick     = tick;
  assign bus.a        = a_q;
  assign bus.b        = b_q;

endmodule

// File: tb/tb_turn_signal_input.sv
// Directed vector bench for turn_signal_input at default parameters.
module tb_turn_signal_input;

  typedef struct {
    int         edge_n;
    logic       l;
    logic       r;
    logic       h;
    logic [5:0] exp;   // {left_db, right_db, haz_db, tick, a, b}
  } vec_t;

  logic clk;
  logic reset;
  int   edge_cnt;
  int   n_vec;
  int   n_bad;
  vec_t tbl_main[$];
  vec_t tbl_rst[$];

  turn_signal_input_if bus();

  turn_signal_input dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int e, logic l, logic r, logic h, logic [5:0] x);
    vec_t v;
    v.edge_n = e; v.l = l; v.r = r; v.h = h; v.exp = x;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {bus.left_db, bus.right_db, bus.haz_db, bus.tick, bus.a, bus.b};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got ldb/rdb/hdb/tick/a/b=%b, expected %b",
               name, edge_cnt, got, exp);
    end
  endtask

  task automatic to_edge(input int n);
    while (edge_cnt < n) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    bus.left_sw  = v.l;
    bus.right_sw = v.r;
    bus.haz_sw   = v.h;
    to_edge(v.edge_n);
    check(name, outs(), v.exp);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; edge_cnt = 0;
    reset = 1'b1;
    bus.left_sw = 1'b0; bus.right_sw = 1'b0; bus.haz_sw = 1'b0;

    // Edge numbers count clk edges after reset release.
    tbl_main.push_back(mk( 3, 1, 0, 0, 6'b000100));
    tbl_main.push_back(mk( 7, 1, 0, 0, 6'b000100));
    tbl_main.push_back(mk( 9, 1, 0, 0, 6'b000000));
    tbl_main.push_back(mk(10, 1, 0, 0, 6'b100000));
    tbl_main.push_back(mk(11, 1, 0, 0, 6'b100100));
    tbl_main.push_back(mk(12, 1, 0, 0, 6'b100010));
    tbl_main.push_back(mk(20, 1, 0, 0, 6'b100010));
    tbl_main.push_back(mk(29, 0, 0, 0, 6'b100010));
    tbl_main.push_back(mk(30, 0, 0, 0, 6'b000010));
    tbl_main.push_back(mk(31, 0, 0, 0, 6'b000110));
    tbl_main.push_back(mk(32, 0, 0, 0, 6'b000000));
    tbl_main.push_back(mk(37, 1, 0, 0, 6'b000000));
    tbl_main.push_back(mk(40, 0, 0, 0, 6'b000000));
    tbl_main.push_back(mk(45, 0, 0, 0, 6'b000000));
    tbl_main.push_back(mk(50, 0, 0, 0, 6'b000000));
    tbl_main.push_back(mk(59, 0, 0, 1, 6'b000100));
    tbl_main.push_back(mk(60, 0, 0, 1, 6'b001000));
    tbl_main.push_back(mk(63, 0, 0, 1, 6'b001100));
    tbl_main.push_back(mk(64, 0, 0, 1, 6'b001011));
    tbl_main.push_back(mk(74, 0, 0, 0, 6'b000011));
    tbl_main.push_back(mk(75, 0, 0, 0, 6'b000111));
    tbl_main.push_back(mk(76, 0, 0, 0, 6'b000000));
    tbl_main.push_back(mk(86, 1, 1, 0, 6'b110000));
    tbl_main.push_back(mk(87, 1, 1, 0, 6'b110100));
    tbl_main.push_back(mk(88, 1, 1, 0, 6'b110011));

    tbl_rst.push_back(mk( 2, 0, 1, 0, 6'b000000));
    tbl_rst.push_back(mk( 3, 0, 1, 0, 6'b000100));
    tbl_rst.push_back(mk( 9, 0, 1, 0, 6'b000000));
    tbl_rst.push_back(mk(10, 0, 1, 0, 6'b010000));
    tbl_rst.push_back(mk(12, 0, 1, 0, 6'b010001));

    repeat (2) @(posedge clk);
    #1 check("reset_state", outs(), 6'b000000);

    // Switch held from the first post-release edge.
    bus.left_sw = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    edge_cnt = 0;

    for (int i = 0; i < tbl_main.size(); i++)
      run_vec($sformatf("main[%0d]", i), tbl_main[i]);

    // Drop left so its debounce is mid-CHECK while a=b=1, then reset asynchronously.
    bus.left_sw = 1'b0;
    to_edge(93);
    check("pre_reset", outs(), 6'b110011);
    #2 reset = 1'b1;
    #1 check("async_reset_clear", outs(), 6'b000000);
    @(posedge clk);
    #1 check("reset_held", outs(), 6'b000000);
    @(negedge clk);
    reset = 1'b0;
    edge_cnt = 0;

    for (int i = 0; i < tbl_rst.size(); i++)
      run_vec($sformatf("post_reset[%0d]", i), tbl_rst[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
